pwrseq_gen: RTL and testbench



---
 rtl/pwrseq_gen_pkg.sv | 21 ++
 rtl/pwrseq_gen_tick_gen.sv | 30 +++
 rtl/pwrseq_gen.sv | 179 +++++++++++++++++
 tb/tb_pwrseq_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwrseq_gen_pkg.sv
// Shared types and divider helpers for the power/reset sequencer.
// Imported by the sequencer top and its prescaler.
package pwrseq_gen_pkg;

    typedef enum logic [1:0] {
        OFF,
        RAMP_UP,
        ON,
        RAMP_DOWN
    } pwrseq_state_t;

    localparam int CNT_W = 32;

    typedef logic [CNT_W-1:0] strobe_cnt_t;
    typedef logic [CNT_W-1:0] tick_cnt_t;

    function automatic int calc_div(int clk_hz, int rate_hz);
        return clk_hz / rate_hz;
    endfunction

endpackage

// File: rtl/pwrseq_gen_tick_gen.sv
// Free-running prescaler: one-clock registered pulse every DIV clocks.
// Used for both the strobe and the sequencing tick.
module tick_gen #(
    parameter int  DIV   = 4,
    parameter type cnt_t = logic [31:0]
) (
    input  logic clk,
    input  logic reset_n,
    output logic pulse
);

    localparam cnt_t LAST = cnt_t'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("tick_gen: DIV must be at least 2");
    end

    cnt_t cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= (cnt == LAST);
            cnt   <= (cnt == LAST) ? '0 : cnt + cnt_t'(1);
        end
    end

endmodule

// File: rtl/pwrseq_gen.sv
// N-channel power/reset enable sequencer with ordered ramp-down,
// plus strobe, timebase tick and heartbeat generation.
module pwrseq_gen
    import pwrseq_gen_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int STROBE_HZ = 400_000,
    parameter int TICK_HZ   = 1_000,
    parameter int NUM_CH    = 4,
    parameter int DLY_W     = 12,
    parameter int DN_DLY    = 10,
    parameter int HB_TICKS  = 500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en_req,
    input  logic [NUM_CH*DLY_W-1:0] dly_cfg,
    output logic                    strobe,
    output logic                    tick,
    output logic                    heartbeat,
    output logic [NUM_CH-1:0]       ch_en,
    output logic                    ready,
    output logic                    busy
);

    localparam int SDIV = calc_div(CLK_HZ, STROBE_HZ);
    localparam int TDIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int IW   = $clog2(NUM_CH + 1);
    localparam int HW   = $clog2(HB_TICKS + 1);

    localparam logic [IW-1:0]    LAST_CH = IW'(NUM_CH - 1);
    localparam logic [DLY_W-1:0] DN      = DLY_W'(DN_DLY);
    localparam logic [HW-1:0]    HB_LAST = HW'(HB_TICKS - 1);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_ch_chk
        $error("pwrseq_gen: NUM_CH must be 1..16");
    end
    if (DN_DLY < 0 || DN_DLY >= (1 << DLY_W)) begin : g_dn_chk
        $error("pwrseq_gen: DN_DLY must fit in DLY_W bits");
    end
    if (HB_TICKS < 1) begin : g_hb_chk
        $error("pwrseq_gen: HB_TICKS must be at least 1");
    end

    tick_gen #(.DIV(SDIV), .cnt_t(strobe_cnt_t)) u_strobe (
        .clk     (clk),
        .reset_n (reset_n),
        .pulse   (strobe)
    );

    tick_gen #(.DIV(TDIV), .cnt_t(tick_cnt_t)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .pulse   (tick)
    );

    logic [HW-1:0] hb_cnt;
    logic          hb_q;
    logic          hb_wrap;

    assign hb_wrap = tick && (hb_cnt == HB_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_cnt <= '0;
            hb_q   <= 1'b0;
        end else if (tick) begin
            hb_cnt <= hb_wrap ? '0 : hb_cnt + HW'(1);
            hb_q   <= hb_q ^ hb_wrap;
        end
    end

    // Toggle is visible in the wrapping tick's own cycle.
    assign heartbeat = hb_q ^ hb_wrap;

    pwrseq_state_t                   state, state_n;
    logic [IW-1:0]                   idx, idx_n;
    logic [DLY_W-1:0]                dcnt, dcnt_n;
    logic [NUM_CH-1:0][DLY_W-1:0]    cfg_q;
    logic [NUM_CH-1:0]               ch_n;
    logic [NUM_CH-1:0]               sel;
    logic [DLY_W-1:0]                cur_dly;
    logic                            load;

    always_comb begin
        cur_dly = '0;
        sel     = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (idx == IW'(k)) begin
                cur_dly = cfg_q[k];
                sel[k]  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        dcnt_n  = dcnt;
        ch_n    = ch_en;
        load    = 1'b0;
        unique case (state)
            OFF: begin
                ch_n = '0;
                if (en_req) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    dcnt_n  = '0;
                    state_n = RAMP_UP;
                end
            end
            RAMP_UP: begin
                if (!en_req) begin
                    // Preloading DN makes the top channel drop on the next clock.
                    if (idx == '0) begin
                        state_n = OFF;
                    end else begin
                        state_n = RAMP_DOWN;
                        idx_n   = idx - IW'(1);
                        dcnt_n  = DN;
                    end
                end else if (dcnt == cur_dly) begin
                    ch_n   = ch_en | sel;
                    dcnt_n = '0;
                    idx_n  = idx + IW'(1);
                    if (idx == LAST_CH) begin
                        state_n = ON;
                    end
                end else if (tick) begin
                    dcnt_n = dcnt + DLY_W'(1);
                end
            end
            ON: begin
                if (!en_req) begin
                    state_n = RAMP_DOWN;
                    idx_n   = LAST_CH;
                    dcnt_n  = DN;
                end
            end
            RAMP_DOWN: begin
                if (dcnt == DN) begin
                    ch_n   = ch_en & ~sel;
                    dcnt_n = '0;
                    if (idx == '0) begin
                        state_n = OFF;
                    end else begin
                        idx_n = idx - IW'(1);
                    end
                end else if (tick) begin
                    dcnt_n = dcnt + DLY_W'(1);
                end
            end
            default: state_n = OFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= OFF;
            idx   <= '0;
            dcnt  <= '0;
            cfg_q <= '0;
            ch_en <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            dcnt  <= dcnt_n;
            ch_en <= ch_n;
            busy  <= (state_n == RAMP_UP) || (state_n == RAMP_DOWN);
            ready <= (state_n == ON);
            if (load) begin
                cfg_q <= dly_cfg;
            end
        end
    end

endmodule

// File: tb/tb_pwrseq_gen.sv
// Randomized self-checking bench for pwrseq_gen against an
// event-time reference model of the sequencing rules.
module tb_pwrseq_gen;

    localparam int CLK_HZ    = 1000;
    localparam int STROBE_HZ = 250;
    localparam int TICK_HZ   = 100;
    localparam int NUM_CH    = 3;
    localparam int DLY_W     = 4;
    localparam int DN_DLY    = 2;
    localparam int HB_TICKS  = 3;
    localparam int SDIV      = CLK_HZ / STROBE_HZ;
    localparam int TDIV      = CLK_HZ / TICK_HZ;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic                    en_req = 1'b0;
    logic [NUM_CH*DLY_W-1:0] dly_cfg = '0;
    logic                    strobe;
    logic                    tick;
    logic                    heartbeat;
    logic [NUM_CH-1:0]       ch_en;
    logic                    ready;
    logic                    busy;

    pwrseq_gen #(
        .CLK_HZ    (CLK_HZ),
        .STROBE_HZ (STROBE_HZ),
        .TICK_HZ   (TICK_HZ),
        .NUM_CH    (NUM_CH),
        .DLY_W     (DLY_W),
        .DN_DLY    (DN_DLY),
        .HB_TICKS  (HB_TICKS)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en_req    (en_req),
        .dly_cfg   (dly_cfg),
        .strobe    (strobe),
        .tick      (tick),
        .heartbeat (heartbeat),
        .ch_en     (ch_en),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef enum {M_OFF, M_UP, M_ON, M_DN} mode_t;

    int    checks = 0;
    int    errors = 0;
    int    n = 0;
    mode_t mode = M_OFF;
    int    lvl = 0;
    int    next_evt = 0;
    int    cfg_m[NUM_CH];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, n);
        end
    endtask

    // Cycle in which a channel changes for a stage active from cycle s:
    // delay 0 -> next cycle, else two cycles after the d-th tick at/after s.
    function automatic int due(input int s, input int d);
        int first;
        if (d == 0) return s + 1;
        first = ((s + TDIV - 1) / TDIV) * TDIV;
        if (first < TDIV) first = TDIV;
        return first + (d - 1) * TDIV + 2;
    endfunction

    task automatic model_reset();
        n        = 0;
        mode     = M_OFF;
        lvl      = 0;
        next_evt = 0;
    endtask

    task automatic model_edge();
        n++;
        case (mode)
            M_OFF: if (en_req) begin
                for (int k = 0; k < NUM_CH; k++)
                    cfg_m[k] = int'(dly_cfg[k*DLY_W +: DLY_W]);
                mode     = M_UP;
                lvl      = 0;
                next_evt = due(n, cfg_m[0]);
            end
            M_UP: if (!en_req) begin
                if (lvl == 0) begin
                    mode = M_OFF;
                end else begin
                    mode     = M_DN;
                    next_evt = n + 1;
                end
            end else if (n == next_evt) begin
                lvl++;
                if (lvl == NUM_CH) mode = M_ON;
                else next_evt = due(n, cfg_m[lvl]);
            end
            M_ON: if (!en_req) begin
                mode     = M_DN;
                next_evt = n + 1;
            end
            M_DN: if (n == next_evt) begin
                lvl--;
                if (lvl == 0) mode = M_OFF;
                else next_evt = due(n, DN_DLY);
            end
            default: mode = M_OFF;
        endcase
    endtask

    task automatic compare_all();
        check("ch_en", 32'(ch_en), 32'((1 << lvl) - 1));
        check("ready", 32'(ready), 32'(mode == M_ON));
        check("busy", 32'(busy), 32'(mode == M_UP || mode == M_DN));
        check("strobe", 32'(strobe), 32'(n > 0 && n % SDIV == 0));
        check("tick", 32'(tick), 32'(n > 0 && n % TDIV == 0));
        check("heartbeat", 32'(heartbeat),
              32'((n / (TDIV * HB_TICKS)) % 2));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic wait_lvl(input int target, input int bound);
        int k = 0;
        while (lvl != target && k < bound) begin
            step();
            k++;
        end
        if (lvl != target) check("wait_lvl", 32'(lvl), 32'(target));
    endtask

    task automatic wait_on(input int bound);
        int k = 0;
        while (mode != M_ON && k < bound) begin
            step();
            k++;
        end
        if (mode != M_ON) check("wait_on", 32'(mode), 32'(M_ON));
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        compare_all();
    endtask

    function automatic logic [NUM_CH*DLY_W-1:0] rand_cfg(input int hi);
        logic [NUM_CH*DLY_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_CH; k++)
            r[k*DLY_W +: DLY_W] = DLY_W'($urandom_range(0, hi));
        return r;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        release_reset();

        // Idle: prescalers and heartbeat only.
        run(40);

        // Full ramp-up with dly_cfg scrambled after the latch instant.
        dly_cfg = {4'd1, 4'd2, 4'd0};
        en_req  = 1'b1;
        step();
        repeat (80) begin
            dly_cfg = rand_cfg(15);
            step();
        end

        // Ordered ramp-down from ON.
        en_req = 1'b0;
        run(70);

        // Abort mid ramp-up with two channels on.
        dly_cfg = {4'd3, 4'd0, 4'd1};
        en_req  = 1'b1;
        wait_lvl(2, 200);
        en_req = 1'b0;
        run(50);

        // Re-request during ramp-down; fresh config latched after OFF.
        dly_cfg = '0;
        en_req  = 1'b1;
        wait_on(200);
        en_req = 1'b0;
        run(3);
        en_req  = 1'b1;
        dly_cfg = {4'd0, 4'd1, 4'd2};
        run(120);

        // Asynchronous reset mid ramp-up.
        en_req = 1'b0;
        run(60);
        dly_cfg = {4'd3, 4'd3, 4'd0};
        en_req  = 1'b1;
        wait_lvl(1, 200);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_ch_en", 32'(ch_en), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_strobe", 32'(strobe), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        en_req = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
        run(35);

        // Random requests and config churn.
        repeat (40) begin
            en_req  = 1'($urandom_range(0, 1));
            dly_cfg = rand_cfg(2);
            repeat ($urandom_range(1, 60)) begin
                step();
                if ($urandom_range(0, 3) == 0) dly_cfg = rand_cfg(2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
